// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - op codes, slot states and alu function shared by the arbiter slice
package alu_share_arbiter_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_BAD = 3'b111
    } alu_op_e;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

    localparam int DATA_W = 32;

    // Shifts use the whole 32-bit b, so any amount of 32 or more clears the result.
    function automatic logic [DATA_W-1:0] alu_eval(input logic [2:0] op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        case (alu_op_e'(op))
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SHL:  r = (b > 32'd31) ? '0 : (a << b[4:0]);
            OP_SHR:  r = (b > 32'd31) ? '0 : (a >> b[4:0]);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rtl/alu_share_arbiter_rr_arbiter.sv - combinational round-robin picker starting after the last winner
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (en && !found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one alu among NUM_REQ requesters via a single backpressured result slot
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*3-1:0] req_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [ID_W-1:0]      out_id,
    output logic                 out_err,
    output logic [CNT_W-1:0]     ops_cnt
);

    slot_state_e       state_q;
    logic [ID_W-1:0]   last_grant_q;
    logic [31:0]       data_q;
    logic [ID_W-1:0]   id_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               load;
    logic               accept;
    logic [31:0]        win_a;
    logic [31:0]        win_b;
    logic [2:0]         win_op;
    logic [31:0]        alu_d;

    assign out_valid = (state_q == S_FULL);
    assign load      = !out_valid || out_ready;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req     (req_valid),
        .last    (last_grant_q),
        .en      (load),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // gnt is only ever set for a valid requester, so any grant is a transfer.
    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);

    assign win_a  = req_a[32*int'(gnt_idx) +: 32];
    assign win_b  = req_b[32*int'(gnt_idx) +: 32];
    assign win_op = req_op[3*int'(gnt_idx) +: 3];
    assign alu_d  = alu_eval(win_op, win_a, win_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_EMPTY;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            data_q       <= '0;
            id_q         <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (out_valid && out_ready) begin
                cnt_q <= cnt_q + 1'b1;
            end
            case (state_q)
                S_EMPTY: if (accept) state_q <= S_FULL;
                S_FULL:  if (out_ready && !accept) state_q <= S_EMPTY;
                default: state_q <= S_EMPTY;
            endcase
            if (accept) begin
                data_q       <= alu_d;
                id_q         <= gnt_idx;
                err_q        <= (win_op == OP_BAD);
                last_grant_q <= gnt_idx;
            end
        end
    end

    assign out_data = data_q;
    assign out_id   = id_q;
    assign out_err  = err_q;
    assign ops_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized and directed bench for alu_share_arbiter against a behavioural model
module tb_alu_share_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [11:0]  req_op;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_id;
    logic         out_err;
    logic [15:0]  ops_cnt;

    int checks;
    int failures;

    bit          m_valid;
    logic [31:0] m_data;
    int          m_id;
    bit          m_err;
    logic [15:0] m_cnt;
    int          m_last;

    alu_share_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_err   (out_err),
        .ops_cnt   (ops_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned sh;
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: begin
                if (b >= 32) return 32'd0;
                sh = longint'(a) * (64'd1 << b);
                return sh[31:0];
            end
            6: begin
                if (b >= 32) return 32'd0;
                return a / (32'd1 << b);
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_winner();
        int idx;
        if (m_valid && !out_ready) return -1;
        for (int k = 1; k <= 4; k++) begin
            idx = (m_last + k) % 4;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int w;
        logic [3:0] r;
        w = model_winner();
        r = 4'b0000;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_id = 0; m_err = 0; m_cnt = 0; m_last = 3;
    endtask

    task automatic set_req(input int i, input int op, input logic [31:0] a, input logic [31:0] b);
        req_op[3*i +: 3] = 3'(op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic step();
        int w;
        int op;
        w = model_winner();
        @(posedge clk);
        if (m_valid && out_ready) m_cnt = m_cnt + 16'd1;
        if (w >= 0) begin
            op      = int'(req_op[3*w +: 3]);
            m_valid = 1;
            m_data  = model_alu(op, req_a[32*w +: 32], req_b[32*w +: 32]);
            m_id    = w;
            m_err   = (op == 7);
            m_last  = w;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 0; req_a = 0; req_b = 0; req_op = 0; out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_id !== 2'd0 || out_err !== 1'b0 || ops_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_values got v=%b d=%h id=%0d e=%b cnt=%0d want all zero", out_valid, out_data, out_id, out_err, ops_cnt);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp;
        req_valid = 4'hF; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, $urandom_range(0, 6), $urandom, $urandom_range(0, 40));
        for (int i = 0; i < 8; i++) begin
            #2;
            exp = 4'b0000;
            exp[i % 4] = 1'b1;
            checks++;
            if (req_ready !== exp || req_ready !== exp_ready()) begin
                failures++;
                $display("FAIL rotation_ready[%0d] got %b want %b", i, req_ready, exp);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'(i % 4) || out_data !== m_data) begin
                failures++;
                $display("FAIL rotation_result[%0d] got v=%b id=%0d d=%h want v=1 id=%0d d=%h", i, out_valid, out_id, out_data, i % 4, m_data);
            end
        end
        req_valid = 4'h0;
        step();
        checks++;
        if (ops_cnt !== 16'd8 || ops_cnt !== m_cnt || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rotation_count got cnt=%0d v=%b want cnt=8 v=0", ops_cnt, out_valid);
        end
    endtask

    task automatic test_async_reset();
        req_valid = 4'b0001; out_ready = 1'b0;
        set_req(0, 0, 32'd5, 32'd6);
        step();
        req_valid = 4'h0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || ops_cnt !== 16'd0) begin
            failures++;
            $display("FAIL async_reset got v=%b cnt=%0d want v=0 cnt=0", out_valid, ops_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = 4'hF; out_ready = 1'b1;
        #2;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL first_grant_after_reset got %b want 0001", req_ready);
        end
        step();
        req_valid = 4'h0;
        step();
    endtask

    task automatic test_arith();
        out_ready = 1'b1;
        req_valid = 4'b0010;
        set_req(1, 0, 32'hFFFF_FFFF, 32'd1);
        step();
        checks++;
        if (out_data !== 32'd0 || out_id !== 2'd1 || out_err !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL add_wrap got d=%h id=%0d e=%b want d=0 id=1 e=0", out_data, out_id, out_err);
        end
        req_valid = 4'b0100;
        set_req(2, 5, 32'd1, 32'd31);
        step();
        checks++;
        if (out_data !== 32'h8000_0000 || out_id !== 2'd2) begin
            failures++;
            $display("FAIL shl31 got d=%h id=%0d want d=80000000 id=2", out_data, out_id);
        end
        set_req(2, 5, 32'd1, 32'd32);
        step();
        checks++;
        if (out_data !== 32'd0) begin
            failures++;
            $display("FAIL shl32 got d=%h want 0", out_data);
        end
        set_req(2, 6, 32'h8000_0000, 32'd31);
        step();
        checks++;
        if (out_data !== 32'd1) begin
            failures++;
            $display("FAIL shr_logical got d=%h want 1", out_data);
        end
        req_valid = 4'h0;
        step();
    endtask

    task automatic test_hold();
        logic [3:0] exp;
        out_ready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_req(i, 4, $urandom, $urandom);
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            checks++;
            if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== m_data || out_id !== 2'(m_id)) begin
                failures++;
                $display("FAIL hold[%0d] got rdy=%b v=%b d=%h id=%0d want rdy=0000 v=1 d=%h id=%0d", i, req_ready, out_valid, out_data, out_id, m_data, m_id);
            end
            step();
        end
        out_ready = 1'b1;
        #2;
        exp = 4'b0000;
        exp[(m_last + 1) % 4] = 1'b1;
        checks++;
        if (req_ready !== exp) begin
            failures++;
            $display("FAIL hold_release got %b want %b", req_ready, exp);
        end
        step();
        req_valid = 4'h0;
        step();
    endtask

    task automatic test_err();
        out_ready = 1'b1;
        req_valid = 4'b1000;
        set_req(3, 7, 32'h1234_5678, 32'h9);
        step();
        checks++;
        if (out_err !== 1'b1 || out_data !== 32'd0 || out_id !== 2'd3) begin
            failures++;
            $display("FAIL bad_op got e=%b d=%h id=%0d want e=1 d=0 id=3", out_err, out_data, out_id);
        end
        set_req(3, 3, 32'h00F0, 32'h0F00);
        step();
        checks++;
        if (out_err !== 1'b0 || out_data !== 32'h0FF0) begin
            failures++;
            $display("FAIL err_clear got e=%b d=%h want e=0 d=00000ff0", out_err, out_data);
        end
        req_valid = 4'h0;
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        req_valid = 4'b0100;
        set_req(2, 0, 32'd10, 32'd20);
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if (req_ready !== 4'b0100) begin
                failures++;
                $display("FAIL solo_req2[%0d] got %b want 0100", i, req_ready);
            end
            step();
        end
        req_valid = 4'b0101;
        #2;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rotate_from2 got %b want 0001", req_ready);
        end
        step();
        req_valid = 4'h0;
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            req_valid = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++)
                set_req(i, $urandom_range(0, 7), $urandom,
                        ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
            #2;
            checks++;
            if (req_ready !== exp_ready()) begin
                failures++;
                $display("FAIL rand_ready[%0d] got %b want %b", n, req_ready, exp_ready());
            end
            step();
            checks++;
            if (out_valid !== m_valid || ops_cnt !== m_cnt ||
                (m_valid && (out_data !== m_data || out_id !== 2'(m_id) || out_err !== m_err))) begin
                failures++;
                $display("FAIL rand_out[%0d] got v=%b d=%h id=%0d e=%b cnt=%0d want v=%b d=%h id=%0d e=%b cnt=%0d",
                         n, out_valid, out_data, out_id, out_err, ops_cnt, m_valid, m_data, m_id, m_err, m_cnt);
            end
        end
        req_valid = 4'h0;
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_rotation();
        test_async_reset();
        test_arith();
        test_hold();
        test_err();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
